// File: rtl/detector_jogada.sv
//------------------------------------------------------------------------------
// detector_jogada: synchronises and debounces the push-buttons, then turns each
// clean one-hot press into a latched play value with a single-cycle pulse.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module detector_jogada #(
   parameter int N_BOTOES        = 4,
   parameter int DEBOUNCE_CICLOS = 4
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [N_BOTOES-1:0] botoes,
   input  logic                habilita,
   input  logic                limpa,
   output logic [N_BOTOES-1:0] jogada,
   output logic                jogada_feita,
   output logic                jogada_invalida,
   output logic [3:0]          db_estado
);

   localparam int               CNT_W   = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

   typedef enum logic [3:0] {
      ESPERA   = 4'h0,
      REGISTRA = 4'h1,
      INVALIDA = 4'h2,
      SOLTURA  = 4'h3
   } estado_t;

   estado_t             estado;
   estado_t             proximo;
   logic [N_BOTOES-1:0] sync1;
   logic [N_BOTOES-1:0] sync2;
   logic [N_BOTOES-1:0] candidato;
   logic [N_BOTOES-1:0] estavel;
   logic [CNT_W-1:0]    cnt;
   logic                carregar;
   logic                nenhum;
   logic                um_so;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= botoes;
         sync2 <= sync1;
      end
   end

   // A level is accepted only after DEBOUNCE_CICLOS further identical samples.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         candidato <= '0;
         cnt       <= '0;
         estavel   <= '0;
      end else if (sync2 != candidato) begin
         candidato <= sync2;
         cnt       <= '0;
      end else if (cnt < CNT_MAX) begin
         cnt <= cnt + CNT_W'(1);
      end else begin
         estavel <= candidato;
      end
   end

   assign nenhum = (estavel == '0);
   assign um_so  = !nenhum && ((estavel & (estavel - N_BOTOES'(1))) == '0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado <= ESPERA;
      end else begin
         estado <= proximo;
      end
   end

   always_comb begin
      proximo         = estado;
      carregar        = 1'b0;
      jogada_feita    = 1'b0;
      jogada_invalida = 1'b0;
      db_estado       = 4'hE;
      case (estado)
         ESPERA: begin
            db_estado = 4'h0;
            if (!nenhum) begin
               if (!um_so) begin
                  proximo = INVALIDA;
               end else if (habilita) begin
                  proximo  = REGISTRA;
                  carregar = 1'b1;
               end else begin
                  proximo = SOLTURA;
               end
            end
         end
         REGISTRA: begin
            db_estado    = 4'h1;
            jogada_feita = 1'b1;
            proximo      = SOLTURA;
         end
         INVALIDA: begin
            db_estado       = 4'h2;
            jogada_invalida = 1'b1;
            proximo         = SOLTURA;
         end
         SOLTURA: begin
            db_estado = 4'h3;
            if (nenhum) begin
               proximo = ESPERA;
            end
         end
         default: begin
            proximo   = ESPERA;
            db_estado = 4'hE;
         end
      endcase
   end

   // A load on the same edge as limpa takes priority over the clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         jogada <= '0;
      end else if (carregar) begin
         jogada <= estavel;
      end else if (limpa) begin
         jogada <= '0;
      end
   end

endmodule

`default_nettype wire

// File: doc/detector_jogada.md
Name: detector_jogada

Overview:
- Input-conditioning stage directly upstream of the game datapath/control unit.
- Conditions raw push-buttons through a synchronizer and debouncer, then encodes each valid press into a latched one-hot play value `jogada`.
- Emits a one-cycle `jogada_feita` pulse that the control unit uses to step from waiting into registra/comparacao.
- Rejects multi-button presses and requires full release between plays.

Parameters:
- N_BOTOES, 4, number of buttons and width of `jogada`.
- DEBOUNCE_CICLOS, 4, consecutive synchronized samples (after the first) needed to accept a new button level. Range ≥ 2; the board build uses 50000.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- botoes  in  N_BOTOES  raw asynchronous button levels, 1 = pressed.
- habilita  in  1  from control unit; a play is accepted only while high.
- limpa  in  1  synchronous clear of `jogada` (driven with zeraR).
- jogada  out  N_BOTOES  latched one-hot value of the last accepted play.
- jogada_feita  out  1  one-cycle pulse: valid play accepted.
- jogada_invalida  out  1  one-cycle pulse: more than one button held stable.
- db_estado  out  4  FSM state code for debug.

Behaviour:
- Reset (reset=0, asynchronous) clears every register immediately, including mid-operation:
  - sync FFs, candidate, stable and jogada = 0; debounce counter = 0; state = ESPERA.
  - jogada_feita = 0, jogada_invalida = 0, db_estado = 4'h0.
- Synchronizer: two flip-flops per bit. `s` is the second-stage output.
- Debouncer, per clock:
  - s ≠ candidate: candidate ← s, cnt ← 0.
  - Else if cnt < DEBOUNCE_CICLOS-1: cnt ← cnt+1.
  - Else: stable ← candidate. Counter saturates; no wrap.
  - Counter width is clog2(DEBOUNCE_CICLOS).
  - Net effect: a botoes level held ≥ DEBOUNCE_CICLOS+1 cycles reaches `stable`; a level held ≤ DEBOUNCE_CICLOS cycles never does.
- FSM (Moore outputs):
  - ESPERA (4'h0):
    - stable = 0: stay.
    - stable one-hot and habilita=1: → REGISTRA, and jogada ← stable on this same edge.
    - stable nonzero and not one-hot: → INVALIDA (regardless of habilita).
    - stable one-hot and habilita=0: → SOLTURA (press ignored, jogada unchanged).
  - REGISTRA (4'h1): jogada_feita = 1 → SOLTURA.
  - INVALIDA (4'h2): jogada_invalida = 1 → SOLTURA.
  - SOLTURA (4'h3): wait for stable = 0, then → ESPERA. Any button changes while held are ignored.
  - Undefined codes: → ESPERA; db_estado = 4'hE.
- Latency: botoes rises before edge 1, held steady, with FSM in ESPERA and habilita=1:
  - stable updates at edge DEBOUNCE_CICLOS+3.
  - jogada is loaded and jogada_feita is high for exactly the cycle after edge DEBOUNCE_CICLOS+4.
  - With default 4: stable at edge 7; jogada_feita high for the cycle after edge 8.
- `jogada` is valid during the jogada_feita cycle and holds until the next accepted play or limpa.
- limpa=1 clears jogada next edge. If limpa coincides with the ESPERA→REGISTRA load, the load wins.
- habilita is sampled only in ESPERA. Dropping it during REGISTRA/INVALIDA/SOLTURA has no effect.
- At most one pulse (feita or invalida) per press/release cycle. The two pulses are never high together.

Test Plan:
- Reset, habilita=1, botoes=4'b0100 held 10 cycles, then released → exactly one jogada_feita pulse in the cycle after edge 8; jogada=4'b0100 persists after release; db_estado sequence 0,1,3,0.
- Glitch: botoes=4'b0010 for 4 cycles, then 0 → no pulse, jogada unchanged, state stays 0.
- botoes=4'b0011 held 10 cycles → one jogada_invalida pulse, no jogada_feita, jogada unchanged; state 0→2→3, returns to 0 after release.
- habilita=0, botoes=4'b1000 held; raise habilita while still held → no pulse (state 3 until release). Second press of 4'b1000 with habilita=1 → pulse, jogada=4'b1000.
- Hold 4'b0001, then add 4'b0100 during SOLTURA, then release all → only the first pulse, jogada=4'b0001. Next: limpa=1 for one cycle → jogada=0.
- Assert reset=0 for one cycle during SOLTURA → outputs and state zero immediately. After reset=1 with botoes still held at 4'b0001, one new jogada_feita pulse occurs after full debounce latency.
